// File: rtl/axi_burst_pkg.sv
// Shared constants and state encoding for axi_burst_master.
// AXI_ID_WIDTH normally comes from the AXI definitions header; a fallback keeps standalone builds working.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_burst_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AR   = 3'd1;
  localparam logic [2:0] ST_R    = 3'd2;
  localparam logic [2:0] ST_AW   = 3'd3;
  localparam logic [2:0] ST_W    = 3'd4;
  localparam logic [2:0] ST_B    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_AR   = ST_AR,
    S_R    = ST_R,
    S_AW   = ST_AW,
    S_W    = ST_W,
    S_B    = ST_B
  } state_t;

  localparam logic [2:0] AXSIZE_4B     = 3'b010;
  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command -> one sequential AW/W/B or AR/R transaction.
// Optional response checking and the err_o port are enabled by BURST_MASTER_RESP_CHECK_EN.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter logic [`AXI_ID_WIDTH-1:0] ID_P = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [ADDR_W-1:0]        cmd_addr_i,
  input  logic [LEN_W-1:0]         cmd_len_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  output logic                     rd_last_o,
  input  logic                     rd_ready_i,
  output logic                     done_o,
`ifdef BURST_MASTER_RESP_CHECK_EN
  output logic                     err_o,
`endif
  output logic [`AXI_ID_WIDTH-1:0] AXI_AWID,
  output logic [ADDR_W-1:0]        AXI_AWADDR,
  output logic [LEN_W-1:0]         AXI_AWLEN,
  output logic [2:0]               AXI_AWSIZE,
  output logic [1:0]               AXI_AWBURST,
  output logic                     AXI_AWLOCK,
  output logic [3:0]               AXI_AWCACHE,
  output logic [2:0]               AXI_AWPROT,
  output logic [3:0]               AXI_AWQOS,
  output logic                     AXI_AWVALID,
  input  logic                     AXI_AWREADY,
  output logic [DATA_W-1:0]        AXI_WDATA,
  output logic [3:0]               AXI_WSTRB,
  output logic                     AXI_WLAST,
  output logic                     AXI_WVALID,
  input  logic                     AXI_WREADY,
  input  logic [`AXI_ID_WIDTH-1:0] AXI_BID,
  input  logic [1:0]               AXI_BRESP,
  input  logic                     AXI_BVALID,
  output logic                     AXI_BREADY,
  output logic [`AXI_ID_WIDTH-1:0] AXI_ARID,
  output logic [ADDR_W-1:0]        AXI_ARADDR,
  output logic [LEN_W-1:0]         AXI_ARLEN,
  output logic [2:0]               AXI_ARSIZE,
  output logic [1:0]               AXI_ARBURST,
  output logic                     AXI_ARLOCK,
  output logic [3:0]               AXI_ARCACHE,
  output logic [2:0]               AXI_ARPROT,
  output logic [3:0]               AXI_ARQOS,
  output logic                     AXI_ARVALID,
  input  logic                     AXI_ARREADY,
  input  logic [`AXI_ID_WIDTH-1:0] AXI_RID,
  input  logic [DATA_W-1:0]        AXI_RDATA,
  input  logic [1:0]               AXI_RRESP,
  input  logic                     AXI_RLAST,
  input  logic                     AXI_RVALID,
  output logic                     AXI_RREADY
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              awvalid_q, arvalid_q, bready_q, done_q;
  logic              in_r, in_w, w_hs, r_hs, r_end, cnt_at_len;
  logic              unused_inputs;

  assign in_r       = (state == S_R);
  assign in_w       = (state == S_W);
  assign cnt_at_len = (cnt_q == CNT_W'(len_q));
  assign w_hs       = in_w && wr_valid_i && AXI_WREADY;
  assign r_hs       = in_r && AXI_RVALID && rd_ready_i;

  // With checking on, a read also terminates at beat len even if RLAST never arrives.
`ifdef BURST_MASTER_RESP_CHECK_EN
  assign r_end = r_hs && (AXI_RLAST || cnt_at_len);
  assign unused_inputs = ^{AXI_BID, AXI_RID, cmd_addr_i[1:0]};
`else
  assign r_end = r_hs && AXI_RLAST;
  assign unused_inputs = ^{AXI_BID, AXI_RID, AXI_BRESP, AXI_RRESP, cmd_addr_i[1:0]};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt_q <= '0;
          if (cmd_valid_i) begin
            addr_q <= {cmd_addr_i[ADDR_W-1:2], 2'b00};
            len_q  <= cmd_len_i;
            if (cmd_write_i) begin
              state     <= S_AW;
              awvalid_q <= 1'b1;
            end else begin
              state     <= S_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_AR: if (AXI_ARREADY) begin
          arvalid_q <= 1'b0;
          state     <= S_R;
        end
        S_R: if (r_hs) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (r_end) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        S_AW: if (AXI_AWREADY) begin
          awvalid_q <= 1'b0;
          state     <= S_W;
        end
        S_W: if (w_hs) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_at_len) begin
            state    <= S_B;
            bready_q <= 1'b1;
          end
        end
        S_B: if (AXI_BVALID) begin
          bready_q <= 1'b0;
          state    <= S_IDLE;
          done_q   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BURST_MASTER_RESP_CHECK_EN
  // Sticky: bad response codes, or RLAST disagreeing with the beat count.
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((state == S_B && AXI_BVALID && AXI_BRESP != 2'b00) ||
                 (r_hs && (AXI_RRESP != 2'b00 || AXI_RLAST != cnt_at_len))) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`endif

  assign cmd_ready_o = (state == S_IDLE) && !rst_i;
  assign done_o      = done_q;

  assign AXI_AWID    = ID_P;
  assign AXI_AWADDR  = addr_q;
  assign AXI_AWLEN   = len_q;
  assign AXI_AWSIZE  = AXSIZE_4B;
  assign AXI_AWBURST = BURST_INCR;
  assign AXI_AWLOCK  = 1'b0;
  assign AXI_AWCACHE = CACHE_DEFAULT;
  assign AXI_AWPROT  = 3'b000;
  assign AXI_AWQOS   = 4'b0000;
  assign AXI_AWVALID = awvalid_q;

  assign AXI_WDATA   = in_w ? wr_data_i : '0;
  assign AXI_WSTRB   = 4'hF;
  assign AXI_WLAST   = in_w && cnt_at_len;
  assign AXI_WVALID  = in_w && wr_valid_i;
  assign wr_ready_o  = in_w && AXI_WREADY;
  assign AXI_BREADY  = bready_q;

  assign AXI_ARID    = ID_P;
  assign AXI_ARADDR  = addr_q;
  assign AXI_ARLEN   = len_q;
  assign AXI_ARSIZE  = AXSIZE_4B;
  assign AXI_ARBURST = BURST_INCR;
  assign AXI_ARLOCK  = 1'b0;
  assign AXI_ARCACHE = CACHE_DEFAULT;
  assign AXI_ARPROT  = 3'b000;
  assign AXI_ARQOS   = 4'b0000;
  assign AXI_ARVALID = arvalid_q;

  assign AXI_RREADY  = in_r && rd_ready_i;
  assign rd_valid_o  = in_r && AXI_RVALID;
  assign rd_data_o   = in_r ? AXI_RDATA : '0;
  assign rd_last_o   = in_r && AXI_RLAST;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed + randomized bench for axi_burst_master with a memory-backed AXI slave and a reference store.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  localparam int unsigned IDW = `AXI_ID_WIDTH;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            cmd_valid, cmd_ready_o, cmd_write;
  logic [31:0]     cmd_addr;
  logic [7:0]      cmd_len;
  logic [31:0]     wr_data;
  logic            wr_valid, wr_ready_o;
  logic [31:0]     rd_data_o;
  logic            rd_valid_o, rd_last_o, rd_ready;
  logic            done_o;
`ifdef BURST_MASTER_RESP_CHECK_EN
  logic            err_o;
`endif
  logic [IDW-1:0]  AXI_AWID, AXI_ARID, AXI_BID, AXI_RID;
  logic [31:0]     AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_RDATA;
  logic [7:0]      AXI_AWLEN, AXI_ARLEN;
  logic [2:0]      AXI_AWSIZE, AXI_ARSIZE, AXI_AWPROT, AXI_ARPROT;
  logic [1:0]      AXI_AWBURST, AXI_ARBURST, AXI_BRESP, AXI_RRESP;
  logic            AXI_AWLOCK, AXI_ARLOCK;
  logic [3:0]      AXI_AWCACHE, AXI_ARCACHE, AXI_AWQOS, AXI_ARQOS, AXI_WSTRB;
  logic            AXI_AWVALID, AXI_AWREADY, AXI_WLAST, AXI_WVALID, AXI_WREADY;
  logic            AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY;
  logic            AXI_RLAST, AXI_RVALID, AXI_RREADY;

  axi_burst_master dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_last_o(rd_last_o), .rd_ready_i(rd_ready),
    .done_o(done_o),
`ifdef BURST_MASTER_RESP_CHECK_EN
    .err_o(err_o),
`endif
    .AXI_AWID(AXI_AWID), .AXI_AWADDR(AXI_AWADDR), .AXI_AWLEN(AXI_AWLEN), .AXI_AWSIZE(AXI_AWSIZE),
    .AXI_AWBURST(AXI_AWBURST), .AXI_AWLOCK(AXI_AWLOCK), .AXI_AWCACHE(AXI_AWCACHE),
    .AXI_AWPROT(AXI_AWPROT), .AXI_AWQOS(AXI_AWQOS), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WLAST(AXI_WLAST), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BID(AXI_BID), .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARID(AXI_ARID), .AXI_ARADDR(AXI_ARADDR), .AXI_ARLEN(AXI_ARLEN), .AXI_ARSIZE(AXI_ARSIZE),
    .AXI_ARBURST(AXI_ARBURST), .AXI_ARLOCK(AXI_ARLOCK), .AXI_ARCACHE(AXI_ARCACHE),
    .AXI_ARPROT(AXI_ARPROT), .AXI_ARQOS(AXI_ARQOS), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RID(AXI_RID), .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RLAST(AXI_RLAST),
    .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // slave_mem holds what the DUT put on the W bus; ref_mem holds what the bench asked to write.
  logic [31:0] slave_mem [int];
  logic [31:0] ref_mem   [int];
  logic [31:0] wq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int k, input bit from_ref);
    if (from_ref) return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    return slave_mem.exists(k) ? slave_mem[k] : 32'h0;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid"}, 64'(AXI_AWVALID), 64'(0));
    chk({tag, "_arvalid"}, 64'(AXI_ARVALID), 64'(0));
    chk({tag, "_wvalid"},  64'(AXI_WVALID),  64'(0));
    chk({tag, "_wready"},  64'(wr_ready_o),  64'(0));
    chk({tag, "_bready"},  64'(AXI_BREADY),  64'(0));
    chk({tag, "_rready"},  64'(AXI_RREADY),  64'(0));
    chk({tag, "_rdvalid"}, 64'(rd_valid_o),  64'(0));
    chk({tag, "_done"},    64'(done_o),      64'(0));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
    chk_quiet("rst");
`ifdef BURST_MASTER_RESP_CHECK_EN
    chk("rst_err", 64'(err_o), 64'(0));
`endif
    rst_i = 1'b0;
    #1 chk("rst_release_ready", 64'(cmd_ready_o), 64'(1));
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int aw_stall, input logic [1:0] bresp);
    int i;
    int guard;
    int base;
    base = int'(addr[31:2]);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = 8'(len);
    #1 chk("w_cmd_ready", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    cmd_valid = 1'b0;
    chk("awvalid", 64'(AXI_AWVALID), 64'(1));
    chk("awaddr", 64'(AXI_AWADDR), 64'({addr[31:2], 2'b00}));
    chk("awlen", 64'(AXI_AWLEN), 64'(len));
    chk("w_busy_ready", 64'(cmd_ready_o), 64'(0));
    chk("w_done_once", 64'(done_o), 64'(0));
    repeat (aw_stall) begin
      @(negedge clk_i);
      chk("awvalid_hold", 64'(AXI_AWVALID), 64'(1));
      chk("awaddr_hold", 64'(AXI_AWADDR), 64'({addr[31:2], 2'b00}));
    end
    AXI_AWREADY = 1'b1;
    @(negedge clk_i);
    AXI_AWREADY = 1'b0;
    chk("awvalid_drop", 64'(AXI_AWVALID), 64'(0));
    i = 0; guard = 0;
    while (i <= len && guard < 2000) begin
      wr_valid   = ($urandom_range(0, 3) != 0);
      AXI_WREADY = ($urandom_range(0, 3) != 0);
      wr_data    = wq[i];
      #1;
      chk("wvalid_pass", 64'(AXI_WVALID), 64'(wr_valid));
      chk("wready_pass", 64'(wr_ready_o), 64'(AXI_WREADY));
      chk("wlast", 64'(AXI_WLAST), 64'(i == len));
      if (wr_valid && AXI_WREADY) begin
        chk("wdata", 64'(AXI_WDATA), 64'(wq[i]));
        slave_mem[base + i] = AXI_WDATA;
        ref_mem[base + i]   = wq[i];
        i++;
      end
      @(negedge clk_i);
      guard++;
    end
    chk("w_beats", 64'(i), 64'(len + 1));
    wr_valid = 1'b0; AXI_WREADY = 1'b0;
    chk("bready", 64'(AXI_BREADY), 64'(1));
    chk("b_done_early", 64'(done_o), 64'(0));
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
    AXI_BVALID = 1'b1; AXI_BRESP = bresp;
    @(negedge clk_i);
    AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
    chk("w_done", 64'(done_o), 64'(1));
    chk("bready_drop", 64'(AXI_BREADY), 64'(0));
    chk("w_done_ready", 64'(cmd_ready_o), 64'(1));
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input int last_at, input bit toggle);
    int j;
    int guard;
    int base;
    bit rr;
    bit fin;
    base = int'(addr[31:2]);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = 8'(len);
    #1 chk("r_cmd_ready", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    cmd_valid = 1'b0;
    chk("arvalid", 64'(AXI_ARVALID), 64'(1));
    chk("araddr", 64'(AXI_ARADDR), 64'({addr[31:2], 2'b00}));
    chk("arlen", 64'(AXI_ARLEN), 64'(len));
    chk("r_awvalid", 64'(AXI_AWVALID), 64'(0));
    chk("r_done_once", 64'(done_o), 64'(0));
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk_i);
      chk("arvalid_hold", 64'(AXI_ARVALID), 64'(1));
    end
    AXI_ARREADY = 1'b1;
    @(negedge clk_i);
    AXI_ARREADY = 1'b0;
    chk("arvalid_drop", 64'(AXI_ARVALID), 64'(0));
    j = 0; guard = 0; rr = 1'b0; fin = 1'b0;
    while (!fin && guard < 2000) begin
      AXI_RVALID = ($urandom_range(0, 3) != 0);
      AXI_RDATA  = mem_rd(base + j, 1'b0);
      AXI_RLAST  = (j == last_at);
      rr         = toggle ? !rr : ($urandom_range(0, 3) != 0);
      rd_ready   = rr;
      #1;
      chk("rdvalid_pass", 64'(rd_valid_o), 64'(AXI_RVALID));
      chk("rready_pass", 64'(AXI_RREADY), 64'(rr));
      if (AXI_RVALID && rr) begin
        chk("rdata", 64'(rd_data_o), 64'(mem_rd(base + j, 1'b1)));
        chk("rd_last", 64'(rd_last_o), 64'(j == last_at));
        fin = (j == last_at);
        j++;
      end
      @(negedge clk_i);
      guard++;
    end
    chk("r_beats", 64'(j), 64'(last_at + 1));
    AXI_RVALID = 1'b0; AXI_RLAST = 1'b0; rd_ready = 1'b0;
    chk("r_done", 64'(done_o), 64'(1));
    chk("r_done_ready", 64'(cmd_ready_o), 64'(1));
    chk("rready_drop", 64'(AXI_RREADY), 64'(0));
  endtask

  task automatic fill_random(input int len);
    wq.delete();
    for (int k = 0; k <= len; k++) wq.push_back($urandom);
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_BID = '0; AXI_BRESP = '0; AXI_BVALID = 1'b0;
    AXI_ARREADY = 1'b0; AXI_RID = '0; AXI_RDATA = '0; AXI_RRESP = '0; AXI_RLAST = 1'b0; AXI_RVALID = 1'b0;

    do_reset();
    chk("wstrb", 64'(AXI_WSTRB), 64'(4'hF));
    chk("awsize", 64'(AXI_AWSIZE), 64'(3'b010));
    chk("arburst", 64'(AXI_ARBURST), 64'(2'b01));
    chk("arcache", 64'(AXI_ARCACHE), 64'(4'b0011));

    // Directed write/read-back at 0x100; the read is issued in the done cycle.
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(32'h100, 3, 2, 2'b00);
    do_read(32'h100, 3, 3, 1'b1);

    // Single-beat write and read at the top word of a 512 B block.
    fill_random(0);
    do_write(32'h1FC, 0, 0, 2'b00);
    do_read(32'h1FC, 0, 0, 1'b0);

    // Reset during the third W beat of a len-7 write.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 8'd7;
    @(negedge clk_i);
    cmd_valid = 1'b0; AXI_AWREADY = 1'b1;
    @(negedge clk_i);
    AXI_AWREADY = 1'b0; wr_valid = 1'b1; AXI_WREADY = 1'b1; wr_data = 32'h5555_0000;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk_quiet("midrst");
    chk("midrst_wlast", 64'(AXI_WLAST), 64'(0));
    chk("midrst_ready", 64'(cmd_ready_o), 64'(0));
    rst_i = 1'b0; wr_valid = 1'b0; AXI_WREADY = 1'b0;
    #1 chk("midrst_idle_ready", 64'(cmd_ready_o), 64'(1));
    @(negedge clk_i);
    chk("midrst_no_done", 64'(done_o), 64'(0));
    fill_random(2);
    do_write(32'h200, 2, 1, 2'b00);
    do_read(32'h200, 2, 2, 1'b1);

    // Randomized traffic, unaligned addresses included.
    for (int n = 0; n < 8; n++) begin
      logic [31:0] a;
      int l;
      a = $urandom & 32'h0000_0FFF;
      l = $urandom_range(0, 15);
      fill_random(l);
      do_write(a, l, $urandom_range(0, 3), 2'b00);
      do_read(a, l, l, 1'($urandom_range(0, 1)));
    end

`ifdef BURST_MASTER_RESP_CHECK_EN
    chk("err_clean", 64'(err_o), 64'(0));
    fill_random(1);
    do_write(32'h300, 1, 0, 2'b10);
    chk("err_bresp", 64'(err_o), 64'(1));
    do_read(32'h300, 1, 1, 1'b0);
    chk("err_sticky", 64'(err_o), 64'(1));
    do_reset();
    do_read(32'h100, 3, 1, 1'b0);
    chk("err_early_rlast", 64'(err_o), 64'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
